// File: rtl/key_pkg.sv
// Shared definitions for the push-button front-end.
//   key_state_t     : per-channel debounce FSM states
//   KEY_*           : bit index of each board key in the key vectors
//   DEFAULT_*       : default timing for a 12 MHz system clock
package key_pkg;

  typedef enum logic [1:0] {
    StReleased,
    StPressWait,
    StPressed,
    StReleaseWait
  } key_state_t;

  localparam int unsigned KEY_ACTION  = 0;
  localparam int unsigned KEY_REACT   = 1;
  localparam int unsigned KEY_AVERAGE = 2;
  localparam int unsigned KEY_COMPARE = 3;

  // 20 ms debounce and 1 s long-press at 12 MHz
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 240000;
  localparam int unsigned DEFAULT_HOLD_CYCLES     = 12000000;

endpackage

// File: rtl/key_debounce_channel.sv
// Single key channel: 2-FF synchroniser, debounce FSM, hold timer.
//   clk_i     : system clock
//   rst_i     : synchronous reset, active-high
//   key_n_i   : raw asynchronous key, 0 = pressed
//   level_o   : debounced level, 1 = pressed
//   press_o   : one-cycle pulse on accepted press
//   release_o : one-cycle pulse on accepted release
//   hold_o    : one-cycle pulse when held HOLD_CYCLES past acceptance
module key_debounce_channel
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEFAULT_HOLD_CYCLES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_n_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic hold_o
);

  localparam int unsigned CntW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);

  localparam logic [CntW-1:0]  CntLast  = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldMax  = HoldW'(HOLD_CYCLES);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             s;
  key_state_t       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             hold_q, hold_d;

  // Synchronised key, 1 = pressed
  assign s = ~sync2_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hold_cnt_d = hold_cnt_q;
    level_d    = level_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    hold_d     = 1'b0;

    // Hold timer runs through release glitches; saturates so it pulses once
    if ((state_q == StPressed) || (state_q == StReleaseWait)) begin
      if (hold_cnt_q != HoldMax) begin
        hold_cnt_d = hold_cnt_q + HoldW'(1);
        hold_d     = (hold_cnt_q == HoldLast);
      end
    end

    unique case (state_q)
      StReleased: begin
        hold_cnt_d = '0;
        if (s) begin
          state_d = StPressWait;
          cnt_d   = CntW'(1);
        end else begin
          cnt_d = '0;
        end
      end
      StPressWait: begin
        if (!s) begin
          state_d = StReleased;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d    = StPressed;
          cnt_d      = '0;
          hold_cnt_d = '0;
          level_d    = 1'b1;
          press_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StPressed: begin
        if (!s) begin
          state_d = StReleaseWait;
          cnt_d   = CntW'(1);
        end
      end
      StReleaseWait: begin
        if (s) begin
          state_d = StPressed;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d    = StReleased;
          cnt_d      = '0;
          hold_cnt_d = '0;
          level_d    = 1'b0;
          release_d  = 1'b1;
          // Release wins over a coinciding hold terminal
          hold_d     = 1'b0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      state_q    <= StReleased;
      cnt_q      <= '0;
      hold_cnt_q <= '0;
      level_q    <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      hold_q     <= 1'b0;
    end else begin
      sync1_q    <= key_n_i;
      sync2_q    <= sync1_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hold_cnt_q <= hold_cnt_d;
      level_q    <= level_d;
      press_q    <= press_d;
      release_q  <= release_d;
      hold_q     <= hold_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign hold_o    = hold_q;

endmodule

// File: rtl/key_conditioner.sv
// Push-button front-end: synchronises, debounces and edge-detects N_KEYS
// active-low keys into registered level and one-cycle event pulses.
//   clk         : system clock (12 MHz)
//   rst         : synchronous reset, active-high
//   key_n       : raw asynchronous keys, 0 = pressed
//   key_level   : debounced level, 1 = pressed
//   key_press   : one-cycle pulse on accepted press
//   key_release : one-cycle pulse on accepted release
//   key_hold    : one-cycle pulse when held HOLD_CYCLES past acceptance
module key_conditioner
  import key_pkg::*;
#(
  parameter int unsigned N_KEYS          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEFAULT_HOLD_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_hold
);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
    key_debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES)
    ) u_chan (
      .clk_i    (clk),
      .rst_i    (rst),
      .key_n_i  (key_n[i]),
      .level_o  (key_level[i]),
      .press_o  (key_press[i]),
      .release_o(key_release[i]),
      .hold_o   (key_hold[i])
    );
  end

endmodule

// File: tb/tb_key_conditioner.sv
module tb_key_conditioner;
  localparam int unsigned NK   = 4;
  localparam int          DEB  = 4;
  localparam int          HOLD = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NK-1:0] key_n = '1;
  logic [NK-1:0] key_level, key_press, key_release, key_hold;

  key_conditioner #(
    .N_KEYS         (NK),
    .DEBOUNCE_CYCLES(DEB),
    .HOLD_CYCLES    (HOLD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_n      (key_n),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_hold   (key_hold)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected outputs for one clock cycle
  typedef struct {
    int            cyc;
    logic [NK-1:0] press;
    logic [NK-1:0] rel;
    logic [NK-1:0] hold;
    logic [NK-1:0] level;
  } exp_t;

  exp_t q[$];

  // Reference model: accepted level flips once the synchronised key has
  // disagreed with it for DEB consecutive cycles; the hold timer counts
  // cycles since acceptance of a press.
  logic [NK-1:0] m_s1 = '1, m_s2 = '1, m_lvl = '0;
  int            m_run[NK];
  int            m_hold[NK];
  int            t_last = 0;

  task automatic tick(input logic r, input logic [NK-1:0] k);
    exp_t e;
    logic s;
    @(negedge clk);
    rst    = r;
    key_n  = k;
    t_last = cyc;
    e.cyc   = cyc + 1;
    e.press = '0;
    e.rel   = '0;
    e.hold  = '0;
    if (r) begin
      m_s1  = '1;
      m_s2  = '1;
      m_lvl = '0;
      for (int i = 0; i < NK; i++) begin
        m_run[i]  = 0;
        m_hold[i] = 0;
      end
    end else begin
      for (int i = 0; i < NK; i++) begin
        s = ~m_s2[i];
        if (m_lvl[i]) begin
          if (m_hold[i] < HOLD) begin
            m_hold[i]++;
            if (m_hold[i] == HOLD) e.hold[i] = 1'b1;
          end
        end else begin
          m_hold[i] = 0;
        end
        if (s != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB) begin
            m_run[i] = 0;
            m_lvl[i] = s;
            if (s) begin
              e.press[i] = 1'b1;
              m_hold[i]  = 0;
            end else begin
              e.rel[i]  = 1'b1;
              e.hold[i] = 1'b0;
            end
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = k;
    end
    e.level = m_lvl;
    q.push_back(e);
  endtask

  task automatic ticks(input int n, input logic r, input logic [NK-1:0] k);
    for (int i = 0; i < n; i++) tick(r, k);
  endtask

  // Event history gathered by the monitor for directed timing checks
  int last_press[NK], last_rel[NK], last_hold[NK];
  int n_press[NK], n_rel[NK], n_hold[NK];

  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      check("missed_cycle", 32'(cyc), 32'(e.cyc));
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      check("key_press",   32'(key_press),   32'(e.press));
      check("key_release", 32'(key_release), 32'(e.rel));
      check("key_hold",    32'(key_hold),    32'(e.hold));
      check("key_level",   32'(key_level),   32'(e.level));
      check("press_rel_excl", 32'(key_press & key_release), 32'd0);
      check("hold_excl", 32'(key_hold & (key_press | key_release)), 32'd0);
    end
    for (int i = 0; i < NK; i++) begin
      if (key_press[i] === 1'b1) begin
        last_press[i] = cyc;
        n_press[i]++;
      end
      if (key_release[i] === 1'b1) begin
        last_rel[i] = cyc;
        n_rel[i]++;
      end
      if (key_hold[i] === 1'b1) begin
        last_hold[i] = cyc;
        n_hold[i]++;
      end
    end
  end

  initial begin
    int c0, c1, np, nh, nr;
    logic [NK-1:0] k, kk;
    for (int i = 0; i < NK; i++) begin
      m_run[i] = 0; m_hold[i] = 0; last_press[i] = -1; last_rel[i] = -1;
      last_hold[i] = -1; n_press[i] = 0; n_rel[i] = 0; n_hold[i] = 0;
    end

    // Reset with all keys pressed: press on all four 6 cycles after rst falls
    ticks(3, 1'b1, 4'b0000);
    tick(1'b0, 4'b0000);
    c0 = t_last;
    ticks(20, 1'b0, 4'b0000);
    for (int i = 0; i < NK; i++) begin
      check("reset_press_lat", 32'(last_press[i]), 32'(c0 + 6));
      check("reset_hold_lat", 32'(last_hold[i]), 32'(c0 + 16));
    end
    tick(1'b0, 4'b1111);
    c1 = t_last;
    ticks(10, 1'b0, 4'b1111);
    check("release_lat", 32'(last_rel[3]), 32'(c1 + 6));

    // Clean press on key 0
    np = n_press[1] + n_press[2] + n_press[3];
    tick(1'b0, 4'b1110);
    c0 = t_last;
    ticks(12, 1'b0, 4'b1110);
    check("clean_press_lat", 32'(last_press[0]), 32'(c0 + 6));
    check("clean_others", 32'(n_press[1] + n_press[2] + n_press[3]), 32'(np));
    ticks(10, 1'b0, 4'b1111);

    // Bounce on key 1 rejected, then 4 clean cycles accepted once
    np = n_press[1];
    ticks(3, 1'b0, 4'b1101);
    ticks(1, 1'b0, 4'b1111);
    ticks(3, 1'b0, 4'b1101);
    ticks(10, 1'b0, 4'b1111);
    check("bounce_reject", 32'(n_press[1]), 32'(np));
    ticks(4, 1'b0, 4'b1101);
    ticks(12, 1'b0, 4'b1111);
    check("four_low_accept", 32'(n_press[1]), 32'(np + 1));

    // Long press on key 2: one hold pulse, no repeat
    nh = n_hold[2];
    tick(1'b0, 4'b1011);
    c0 = t_last;
    ticks(29, 1'b0, 4'b1011);
    tick(1'b0, 4'b1111);
    c1 = t_last;
    ticks(10, 1'b0, 4'b1111);
    check("hold_press_lat", 32'(last_press[2]), 32'(c0 + 6));
    check("hold_lat", 32'(last_hold[2]), 32'(c0 + 16));
    check("hold_once", 32'(n_hold[2]), 32'(nh + 1));
    check("hold_release_lat", 32'(last_rel[2]), 32'(c1 + 6));

    // Release accepted in the hold terminal cycle suppresses the hold pulse
    nh = n_hold[2];
    tick(1'b0, 4'b1011);
    ticks(9, 1'b0, 4'b1011);
    tick(1'b0, 4'b1111);
    c1 = t_last;
    ticks(10, 1'b0, 4'b1111);
    check("coincide_release", 32'(last_rel[2]), 32'(c1 + 6));
    check("coincide_no_hold", 32'(n_hold[2]), 32'(nh));

    // Release glitch on key 3: no release, hold timer not restarted
    nr = n_rel[3];
    tick(1'b0, 4'b0111);
    c0 = t_last;
    ticks(13, 1'b0, 4'b0111);
    ticks(2, 1'b0, 4'b1111);
    ticks(16, 1'b0, 4'b0111);
    check("glitch_no_release", 32'(n_rel[3]), 32'(nr));
    check("glitch_hold_lat", 32'(last_hold[3]), 32'(c0 + 16));
    ticks(10, 1'b0, 4'b1111);

    // Keys 0 and 3 together
    tick(1'b0, 4'b0110);
    c0 = t_last;
    ticks(8, 1'b0, 4'b0110);
    check("simul_k0", 32'(last_press[0]), 32'(c0 + 6));
    check("simul_k3", 32'(last_press[3]), 32'(c0 + 6));
    ticks(10, 1'b0, 4'b1111);

    // Reset in the middle of key 1 debounce aborts the count
    np = n_press[1];
    ticks(4, 1'b0, 4'b1101);
    ticks(2, 1'b1, 4'b1101);
    tick(1'b0, 4'b1101);
    c0 = t_last;
    ticks(10, 1'b0, 4'b1101);
    check("midreset_once", 32'(n_press[1]), 32'(np + 1));
    check("midreset_lat", 32'(last_press[1]), 32'(c0 + 6));
    ticks(10, 1'b0, 4'b1111);

    // Randomised key activity with glitches and occasional resets
    for (int seg = 0; seg < 120; seg++) begin
      k = NK'($urandom);
      for (int d = 0; d < int'($urandom_range(1, 18)); d++) begin
        kk = k;
        if ($urandom_range(0, 5) == 0) kk[$urandom_range(0, NK - 1)] ^= 1'b1;
        tick(($urandom_range(0, 150) == 0), kk);
      end
    end

    ticks(30, 1'b0, 4'b1111);
    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
